// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - multi-cycle core front end: phase counter, PC, fetch tagging, redirects
//
// Purpose:
//   Owns the 4-phase cycle counter (00 -> 01 -> 10 -> 11 -> 00) and the program
//   counter of the multi-cycle core. It drives the phase and address inputs of
//   the instruction memory, tags each fetched word with its PC for decode, and
//   latches branch/jump redirects from execute. A pending redirect is applied at
//   the instruction boundary, which is the edge that leaves phase 11.
//
// Parameters:
//   PC_SIZE        width of the PC and of the branch target
//   RESET_PC       PC loaded on reset (4-byte aligned)
//
// Ports:
//   clk            single clock, all state changes on the rising edge
//   reset          synchronous active-high reset, overrides everything
//   stall          freezes phase, pc and instr_pc while high
//   branch_valid   one-cycle redirect request, sampled even while stalled
//   branch_target  redirect address, low two bits are ignored
//   phase          current phase, to instruction memory and the rest of the core
//   pc             address of the instruction being fetched
//   instr_pc       PC of the word currently on the instruction memory output
//   instr_valid    high during phase 01: instr / instr_pc are valid for decode
//   align_err      one-cycle pulse after a redirect with a misaligned target

module fetch_sequencer #(
  parameter int                 PC_SIZE  = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_valid,
  input  logic [PC_SIZE-1:0] branch_target,
  output logic [1:0]         phase,
  output logic [PC_SIZE-1:0] pc,
  output logic [PC_SIZE-1:0] instr_pc,
  output logic               instr_valid,
  output logic               align_err
);

  typedef enum logic [1:0] {
    PH_ADDR   = 2'b00,  // address presented to instruction memory
    PH_DECODE = 2'b01,  // fetched word and its tag are valid
    PH_EXEC   = 2'b10,
    PH_COMMIT = 2'b11   // leaving this phase is the instruction boundary
  } phase_t;

  localparam logic [PC_SIZE-1:0] PC_STEP = PC_SIZE'(4);

  phase_t             state;
  phase_t             state_next;
  logic               redir_pend;
  logic [PC_SIZE-1:0] redir_target;
  logic [PC_SIZE-1:0] target_aligned;
  logic [PC_SIZE-1:0] pc_seq;
  logic [PC_SIZE-1:0] pc_commit;
  logic               commit;
  logic               target_misaligned;

  // Redirects always land on a word boundary; a misaligned request is still
  // taken, with its low bits cleared, and only flagged through align_err.
  assign target_aligned    = {branch_target[PC_SIZE-1:2], 2'b00};
  assign target_misaligned = (branch_target[1:0] != 2'b00);

  // Sequential fetch wraps modulo 2^PC_SIZE through the natural adder overflow.
  assign pc_seq = pc + PC_STEP;

  // Stall has priority over the commit: a stalled phase-11 cycle is not a boundary.
  assign commit = (state == PH_COMMIT) && !stall;

  // A request arriving in the commit cycle itself is newer than anything stored,
  // so it is used directly and never becomes pending.
  always_comb begin
    pc_commit = pc_seq;
    if (branch_valid) begin
      pc_commit = target_aligned;
    end else if (redir_pend) begin
      pc_commit = redir_target;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      PH_ADDR:   state_next = PH_DECODE;
      PH_DECODE: state_next = PH_EXEC;
      PH_EXEC:   state_next = PH_COMMIT;
      PH_COMMIT: state_next = PH_ADDR;
      default:   state_next = PH_ADDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= PH_ADDR;
      pc           <= RESET_PC;
      instr_pc     <= RESET_PC;
      redir_pend   <= 1'b0;
      redir_target <= '0;
      align_err    <= 1'b0;
    end else begin
      align_err <= branch_valid && target_misaligned;

      // Redirect capture runs every cycle, stalled or not; the latest request
      // overwrites an earlier one that has not been committed yet.
      if (commit) begin
        pc         <= pc_commit;
        redir_pend <= 1'b0;
      end else if (branch_valid) begin
        redir_pend   <= 1'b1;
        redir_target <= target_aligned;
      end

      if (!stall) begin
        state <= state_next;
        // The instruction memory latches its word on the edge leaving phase 00,
        // so the tag is captured on that same edge to stay paired with it.
        if (state == PH_ADDR) begin
          instr_pc <= pc;
        end
      end
    end
  end

  assign phase       = state;
  assign instr_valid = (state == PH_DECODE);

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Front-end sequencer for the multi-cycle core. It owns the 4-phase cycle counter and the program counter, and drives the `phase` and `pc` inputs of the instruction memory. It also tags each fetched word with its PC for the decode stage. Branch and jump redirects from execute are latched and applied at the instruction boundary; a stall input freezes the whole sequence.

## Interface
- `PC_SIZE`, 32, width of PC and branch target
- `RESET_PC`, 0, PC value loaded on reset; must be 4-byte aligned
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset; sampled on `clk` rising edge
- `stall`  in  1  freeze phase, PC and `instr_pc` while high
- `branch_valid`  in  1  one-cycle request to redirect the next fetch
- `branch_target`  in  PC_SIZE  redirect address, valid with `branch_valid`
- `phase`  out  2  current phase, to instruction memory and rest of core
- `pc`  out  PC_SIZE  address of the instruction being fetched
- `instr_pc`  out  PC_SIZE  PC of the word currently on the instruction memory output
- `instr_valid`  out  1  high while `phase==01`: `instr`/`instr_pc` are valid for decode
- `align_err`  out  1  one-cycle pulse: `branch_valid` seen with `branch_target[1:0]!=0`

## Operation
- Phase FSM: 00 -> 01 -> 10 -> 11 -> 00. It advances one state per cycle when `stall==0` and holds when `stall==1`.
- PC commit happens on the edge that leaves phase 11 (not stalled):
  - `pc <= redirect target` if a redirect is pending or `branch_valid` is high that cycle.
  - Otherwise `pc <= pc + 4`.
  - Addition is modulo 2^PC_SIZE: `pc` of all-ones-minus-3 wraps to 0.
- `instr_pc <= pc` on the edge that leaves phase 00 (not stalled). This matches the instruction memory latching `instr` on that same edge.
- Redirect capture:
  - `branch_valid` is sampled every cycle, including during `stall`. It sets `redir_pend` and stores `{branch_target[PC_SIZE-1:2],2'b00}`.
  - A later `branch_valid` before commit overwrites the stored target; the latest one wins.
  - `redir_pend` clears on commit.
  - If `branch_valid` arrives in the same cycle as a commit, the new target is used at that commit and nothing remains pending.
- `align_err` is registered. It pulses the cycle after `branch_valid` with a misaligned target. The redirect still proceeds using the cleared low bits.
- `stall` has priority over commit: a stalled phase-11 cycle does not update `pc`. The commit happens on the first unstalled phase-11 edge.
- `reset` has priority over everything:
  - `phase=00`, `pc=RESET_PC`, `instr_pc=RESET_PC`, `redir_pend=0`, stored target=0, `align_err=0`.
  - `instr_valid` follows from phase 00, so it is 0.
  - Reset mid-sequence discards any pending redirect.

## Timing
- All outputs come from registers (`instr_valid` decodes the `phase` register). Each takes its new value one cycle after the causing edge.
- Unstalled fetch period is 4 cycles:
  - `pc` is stable through phases 00-11.
  - `instr_valid` is high for exactly one cycle per period (phase 01).
- Redirect latency:
  - `branch_valid` in any cycle of period N makes period N+1 fetch the target.
  - Exception: `branch_valid` arriving during the commit cycle of period N is used at that same commit.
- Each stall cycle extends the current phase by one cycle. There is no other timing effect.

## Test plan
- Reset release, no stall, 12 cycles: `phase` goes 00,01,10,11,00,... and `pc` goes 0,4,8 at cycles 0,4,8. `instr_valid` is high at cycles 1,5,9 with `instr_pc`=0,4,8.
- `branch_valid` with target 0x100 during phase 01 of pc=4: the next period has pc=0x100, after that 0x104, and `align_err` stays 0.
- Two redirects in one period (0x40 in phase 00, then 0x80 in phase 11): the next pc is 0x80 and `redir_pend` ends clear, so the following pc is 0x84.
- `stall` held 3 cycles in phase 11 with pc=8, plus `branch_valid`=0x200 during the stall: phase stays 11 and pc stays 8 for 3 cycles. The first unstalled edge loads pc=0x200.
- `RESET_PC`=0xFFFFFFF8 (override), run 3 periods: pc goes FFFFFFF8, FFFFFFFC, 00000000.
- Misaligned target 0x103 in phase 10: `align_err`=1 for one cycle and the next pc is 0x100. Then assert `reset` in phase 10 while a redirect is pending: the next cycle has phase=00 and pc=RESET_PC, and no redirect is applied afterward.
